// File: rtl/alu_pkg.sv
// Shared ALU definitions for the ALU-sharing arbiter.
// Contents:
//   DATA_W / OP_W  - ALU datapath and opcode widths
//   OP_*           - ALU opcode encodings (passed through unchecked; the ALU decodes them)
//   state_e        - arbiter FSM states
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b00101;
  localparam logic [OP_W-1:0] OP_BLTU = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b01110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   in  NUM_REQ  request vector
//   ptr_i   in  IDW      index of the last grant; search starts at ptr_i+1, wrapping
//   en_i    in  1        arbitration enable; no grant when low
//   grant_o out NUM_REQ  one-hot grant (all zero when nothing granted)
//   idx_o   out IDW      encoded index of the granted requester
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o
);

  logic found;
  int   cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // Walk the requesters starting just after the last grant; the last one
    // visited is the previous winner itself, giving it lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand[IDW-1:0];
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational 32-bit ALU between NUM_REQ requesters.
// Round-robin grant with valid/ready handshakes on both request and response
// sides; operands are registered before the ALU and results after it.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready is one-hot, combinational
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   alu_op/alu_a/alu_b    registered operands to the ALU
//   alu_result/alu_zero   ALU outputs, captured at the end of EXEC
//   rsp_valid/rsp_ready   response handshake, rsp_valid one-hot to the owner
//   rsp_result/rsp_zero   captured ALU outputs, shared by all requesters
//   busy                  high in EXEC or RESP
//   owner_id              requester owning the in-flight op
//   ops_done              completed response handshakes, wrapping
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int CNT_W   = 16,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      busy,
  output logic [IDW-1:0]            owner_id,
  output logic [CNT_W-1:0]          ops_done
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0]    ops_done_q, ops_done_d;

  logic                rsp_hs;
  logic                arb_en;
  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_idx;

  // Only the owner's rsp_ready can complete the response.
  assign rsp_hs = (state_q == RESP) && rsp_ready[owner_q];
  // A new op may be accepted in IDLE, or in RESP on the very cycle the current
  // response completes (back-to-back issue). Reset masks grants outright.
  assign arb_en = !reset && ((state_q == IDLE) || rsp_hs);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign req_ready  = grant;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);
  assign owner_id   = owner_q;
  assign ops_done   = ops_done_q;

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      EXEC: begin
        rsp_result_d         = alu_result;
        rsp_zero_d           = alu_zero;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = '0;
          ops_done_d  = ops_done_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // The arbiter only grants in IDLE or on a RESP handshake, so a grant
    // always means: load operands and move to EXEC.
    if (|grant) begin
      alu_op_d = req_op[int'(grant_idx)*OP_W +: OP_W];
      alu_a_d  = req_a[int'(grant_idx)*DATA_W +: DATA_W];
      alu_b_d  = req_b[int'(grant_idx)*DATA_W +: DATA_W];
      owner_d  = grant_idx;
      ptr_d    = grant_idx;
      state_d  = EXEC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      owner_q      <= '0;
      // Pointer at the last index so requester 0 wins the first arbitration.
      ptr_q        <= IDW'(NUM_REQ - 1);
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      ops_done_q   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model standing in
// for the external ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;
  logic        owner_id;
  logic [15:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .owner_id   (owner_id),
    .ops_done   (ops_done)
  );

  // External ALU: branch compares report "taken" on the zero flag.
  always_comb begin
    alu_result = '0;
    alu_zero   = 1'b0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SLL:  alu_result = alu_a << alu_b[4:0];
      OP_BLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      OP_BLTU: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
    if (alu_op == OP_BLT || alu_op == OP_BLTU) alu_zero = alu_result[0];
    else                                       alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 more unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_op[i*5 +: 5]   = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    tick();
    tick();
    settle();
    // Reset state
    check("rst_req_ready",  32'(req_ready), 32'h0);
    check("rst_rsp_valid",  32'(rsp_valid), 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_zero",   32'(rsp_zero), 32'h0);
    check("rst_busy",       32'(busy), 32'h0);
    check("rst_owner",      32'(owner_id), 32'h0);
    check("rst_ops_done",   32'(ops_done), 32'h0);
    check("rst_alu_a",      alu_a, 32'h0);
    check("rst_alu_op",     32'(alu_op), 32'h0);

    // 1: req0 ADD 5+7
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    reset     = 1'b0;
    tick();
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    settle();
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    settle();
    check("t1_exec_busy",  32'(busy), 32'h1);
    check("t1_exec_rspv",  32'(rsp_valid), 32'h0);
    check("t1_exec_rdy",   32'(req_ready), 32'h0);
    check("t1_alu_op",     32'(alu_op), 32'(OP_ADD));
    check("t1_alu_a",      alu_a, 32'd5);
    check("t1_alu_b",      alu_b, 32'd7);
    tick();
    settle();
    check("t1_rsp_valid",  32'(rsp_valid), 32'h1);
    check("t1_rsp_result", rsp_result, 32'd12);
    check("t1_rsp_zero",   32'(rsp_zero), 32'h0);
    tick();
    settle();
    check("t1_ops_done",   32'(ops_done), 32'd1);
    check("t1_idle_rspv",  32'(rsp_valid), 32'h0);
    check("t1_idle_busy",  32'(busy), 32'h0);
    check("t1_alu_a_hold", alu_a, 32'd5);

    // 2: req1 BLTU then BLT on 0x0000000F vs 0xF000000F
    set_req(1, 1'b1, OP_BLTU, 32'h0000000F, 32'hF000000F);
    settle();
    check("t2_bltu_rdy", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    settle();
    check("t2_owner", 32'(owner_id), 32'h1);
    tick();
    settle();
    check("t2_bltu_rspv", 32'(rsp_valid), 32'h2);
    check("t2_bltu_zero", 32'(rsp_zero), 32'h1);
    tick();
    set_req(1, 1'b1, OP_BLT, 32'h0000000F, 32'hF000000F);
    settle();
    check("t2_blt_rdy", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    settle();
    check("t2_blt_zero", 32'(rsp_zero), 32'h0);
    tick();
    settle();
    check("t2_ops_done", 32'(ops_done), 32'd3);

    // 3: both valid continuously, grants alternate starting at 0 after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("t3_rst_ops_done", 32'(ops_done), 32'd0);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_ADD, 32'd10, 32'd20);
    for (int g = 0; g < 4; g++) begin
      settle();
      check($sformatf("t3_grant%0d", g), 32'(req_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      settle();
      check($sformatf("t3_exec_rdy%0d", g), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("t3_rspv%0d", g), 32'(rsp_valid), (g % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("t3_res%0d", g), rsp_result, (g % 2 == 0) ? 32'd2 : 32'd30);
    end
    req_valid = 2'b00;
    tick();
    settle();
    check("t3_ops_done", 32'(ops_done), 32'd4);
    check("t3_idle_busy", 32'(busy), 32'h0);

    // 4 + 6: req0 SLL stalled by rsp_ready, req1 waiting, wrong-owner ready
    rsp_ready = 2'b00;
    set_req(0, 1'b1, OP_SLL, 32'hF, 32'hF);
    set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4);
    settle();
    check("t4_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("t4_hold_rspv%0d", c), 32'(rsp_valid), 32'h1);
      check($sformatf("t4_hold_res%0d", c), rsp_result, 32'h00078000);
      check($sformatf("t4_hold_rdy%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    settle();
    check("t4_hold_ops", 32'(ops_done), 32'd4);
    rsp_ready = 2'b01;
    settle();
    check("t4_same_cycle_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    settle();
    check("t4_rspv_drop", 32'(rsp_valid), 32'h0);
    check("t4_owner1",    32'(owner_id), 32'h1);
    check("t4_ops_done",  32'(ops_done), 32'd5);
    tick();
    settle();
    check("t4_r1_rspv", 32'(rsp_valid), 32'h2);
    check("t4_r1_res",  rsp_result, 32'd7);
    tick();
    settle();
    check("t4_ops_done2", 32'(ops_done), 32'd6);

    // 5: reset during EXEC drops the op
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    settle();
    check("t5_in_exec", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("t5_rspv",     32'(rsp_valid), 32'h0);
    check("t5_busy",     32'(busy), 32'h0);
    check("t5_ops_done", 32'(ops_done), 32'd0);
    check("t5_alu_a",    alu_a, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check($sformatf("t5_no_rsp%0d", c), 32'(rsp_valid), 32'h0);
    end
    check("t5_ops_done_end", 32'(ops_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
